// File: rtl/paint_cursor_ctrl.sv
// Paint cursor controller: tick-paced cursor movement and colour edit.
// Ports: CLOCK_50, reset (sync, active-low), up_n/down_n/left_n/right_n
// (active-low buttons), col_sw[7:0] colour commands, paint_en request;
// cursor_x/cursor_y top-left corner, red/green/blue paint colour,
// tick update pulse, write_enable registered paint strobe.
module paint_cursor_ctrl #(
   parameter int W_RES   = 640,
   parameter int H_RES   = 480,
   parameter int SIZE    = 8,
   parameter int STEP    = 4,
   parameter int DIVISOR = 2000000,
   parameter int CW      = 8,
   parameter int CSTEP   = 16,
   parameter int XW      = 11
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          up_n,
   input  logic          down_n,
   input  logic          left_n,
   input  logic          right_n,
   input  logic [7:0]    col_sw,
   input  logic          paint_en,
   output logic [XW-1:0] cursor_x,
   output logic [XW-1:0] cursor_y,
   output logic [CW-1:0] red,
   output logic [CW-1:0] green,
   output logic [CW-1:0] blue,
   output logic          tick,
   output logic          write_enable
);

   localparam int TW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [TW-1:0] CNT_MAX = TW'(DIVISOR - 1);

   localparam logic [XW-1:0] X_MAX = XW'(W_RES - SIZE);
   localparam logic [XW-1:0] Y_MAX = XW'(H_RES - SIZE);
   localparam logic [XW-1:0] X_INI = XW'((W_RES - SIZE) / 2);
   localparam logic [XW-1:0] Y_INI = XW'((H_RES - SIZE) / 2);
   localparam logic [XW-1:0] STP   = XW'(STEP);

   localparam logic [CW-1:0] CMAX = '1;
   localparam logic [CW-1:0] CST  = CW'(CSTEP);

   logic [TW-1:0] cnt;
   logic [7:0]    samp;
   // Switches seen high during reset stay blocked until observed low.
   logic [7:0]    blk;
   logic [7:0]    rise;

   logic [XW-1:0] nx, ny;
   logic [CW-1:0] nr, ng, nb;

   function automatic logic [XW-1:0] dec_pos(input logic [XW-1:0] p);
      return (p < STP) ? '0 : p - STP;
   endfunction

   // Compare against lim-STP so p+STP can never overflow XW bits.
   function automatic logic [XW-1:0] inc_pos(input logic [XW-1:0] p,
                                             input logic [XW-1:0] lim);
      return (p > lim - STP) ? lim : p + STP;
   endfunction

   function automatic logic [CW-1:0] add_sat(input logic [CW-1:0] c);
      return (c > CMAX - CST) ? CMAX : c + CST;
   endfunction

   function automatic logic [CW-1:0] sub_sat(input logic [CW-1:0] c);
      return (c < CST) ? '0 : c - CST;
   endfunction

   assign tick = reset && (cnt == CNT_MAX);
   assign rise = col_sw & ~samp & ~blk;

   always_comb begin
      nx = cursor_x;
      ny = cursor_y;
      if (!up_n)
         ny = dec_pos(cursor_y);
      else if (!down_n)
         ny = inc_pos(cursor_y, Y_MAX);
      if (!left_n)
         nx = dec_pos(cursor_x);
      else if (!right_n)
         nx = inc_pos(cursor_x, X_MAX);
   end

   always_comb begin
      nr = red;
      ng = green;
      nb = blue;
      priority case (1'b1)
         rise[7]: nr = add_sat(red);
         rise[6]: nr = sub_sat(red);
         rise[5]: ng = add_sat(green);
         rise[4]: ng = sub_sat(green);
         rise[3]: nb = add_sat(blue);
         rise[2]: nb = sub_sat(blue);
         rise[1]: begin
            nr = CMAX;
            ng = CMAX;
            nb = CMAX;
         end
         rise[0]: begin
            nr = '0;
            ng = '0;
            nb = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         cnt          <= '0;
         write_enable <= 1'b0;
         samp         <= '0;
         blk          <= col_sw;
         cursor_x     <= X_INI;
         cursor_y     <= Y_INI;
         red          <= '0;
         green        <= '0;
         blue         <= '0;
      end else begin
         cnt          <= tick ? '0 : cnt + TW'(1);
         write_enable <= paint_en;
         if (tick) begin
            samp     <= col_sw;
            blk      <= blk & col_sw;
            cursor_x <= nx;
            cursor_y <= ny;
            red      <= nr;
            green    <= ng;
            blue     <= nb;
         end
      end
   end

endmodule

// File: doc/paint_cursor_ctrl.md
PAINT_CURSOR_CTRL -- requirements
Module: paint_cursor_ctrl

Interface
REQ-001 SHALL have parameter W_RES, default 640, horizontal resolution in pixels.
REQ-002 SHALL have parameter H_RES, default 480, vertical resolution in pixels.
REQ-003 SHALL have parameter SIZE, default 8, cursor edge length in pixels.
REQ-004 SHALL have parameter STEP, default 4, cursor displacement per tick in pixels.
REQ-005 SHALL have parameter DIVISOR, default 2000000, CLOCK_50 cycles per tick.
REQ-006 SHALL have parameter CW, default 8, colour channel width in bits.
REQ-007 SHALL have parameter CSTEP, default 16, colour increment and decrement amount.
REQ-008 SHALL have parameter XW, default 11, coordinate width in bits.
REQ-009 SHALL have port CLOCK_50, input, 1 bit, system clock; all logic on its rising edge.
REQ-010 SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-011 SHALL have ports up_n, down_n, left_n, right_n, input, 1 bit each, active-low buttons.
REQ-012 SHALL have port col_sw, input, 8 bits: [7] red+, [6] red-, [5] green+, [4] green-, [3] blue+, [2] blue-, [1] white, [0] black.
REQ-013 SHALL have port paint_en, input, 1 bit, request to write the cursor colour.
REQ-014 SHALL have ports cursor_x and cursor_y, output, XW bits each, cursor top-left corner.
REQ-015 SHALL have ports red, green and blue, output, CW bits each, current paint colour.
REQ-016 SHALL have port tick, output, 1 bit, one-cycle pulse marking each update instant.
REQ-017 SHALL have port write_enable, output, 1 bit, registered paint strobe.

Function
REQ-018 Tick counter SHALL count 0..DIVISOR-1 and wrap to 0; tick SHALL be high for exactly the cycle in which the counter equals DIVISOR-1.
REQ-019 All cursor and colour updates SHALL occur only on the clock edge where tick=1; they SHALL take effect the next cycle.
REQ-020 Vertical and horizontal axes SHALL update independently on the same tick, so diagonal movement is allowed.
REQ-021 Button held across ticks SHALL move the cursor by STEP on every tick (auto-repeat).
REQ-022 Both up_n and down_n low SHALL move up only; both left_n and right_n low SHALL move left only.
REQ-023 Up: if cursor_y < STEP then cursor_y SHALL become 0, else cursor_y-STEP.
REQ-024 Down: if cursor_y+STEP > H_RES-SIZE then cursor_y SHALL become H_RES-SIZE, else cursor_y+STEP.
REQ-025 Left and right SHALL follow REQ-023/REQ-024 using cursor_x and W_RES; cursor SHALL never leave [0, RES-SIZE].
REQ-026 col_sw SHALL be sampled into a register on each tick; a colour command SHALL fire only on a 0-to-1 transition of a bit between consecutive tick samples.
REQ-027 At most one colour command SHALL execute per tick; priority SHALL be col_sw[7] (highest) down to col_sw[0] (lowest); other simultaneous edges SHALL be discarded.
REQ-028 Channel+ SHALL add CSTEP, saturating at 2^CW-1; channel- SHALL subtract CSTEP, saturating at 0; no wrap-around.
REQ-029 White SHALL set all channels to 2^CW-1; black SHALL set all channels to 0.
REQ-030 write_enable SHALL equal paint_en delayed by one cycle, independent of tick.
REQ-031 Movement and colour commands on the same tick SHALL both apply.

Reset
REQ-032 While reset=0 at a clock edge: tick counter=0, tick=0, write_enable=0, col_sw sample register=0, red=green=blue=0.
REQ-033 While reset=0: cursor_x=(W_RES-SIZE)/2, cursor_y=(H_RES-SIZE)/2 (defaults 316, 236).
REQ-034 Reset asserted mid-operation SHALL abort pending updates; first tick after release SHALL occur DIVISOR cycles later.
REQ-035 Switch already high at reset release SHALL not fire until released and pressed again.

Verification
REQ-036 DIVISOR=4, reset release, right_n held low for 3 ticks -> cursor_x 316,320,324,328; tick period 4 cycles.
REQ-037 cursor_y=2, up_n and down_n both low -> cursor_y=0 next tick, stays 0 on later ticks.
REQ-038 Default params, col_sw[7] pulsed 16 times -> red 16,32,...,240 then saturates at 255; col_sw[6] pulsed once from 255 -> 239.
REQ-039 col_sw[7] and col_sw[4] rise on same tick -> red+16 only, green unchanged; col_sw held high -> no repeat.
REQ-040 up_n and left_n low from (316,236) -> (312,232) after one tick; reset=0 mid-run -> (316,236), colours 0.
REQ-041 paint_en high for one cycle, in or out of reset -> write_enable high exactly one cycle later only when reset=1.
